emission_alert_manager: RTL and testbench
=========================================

Name: emission_alert_manager

Overview:
- Downstream stage of the CO2 emissions FSM. Consumes its per-cycle warning/critical flags and turns them into a stable alarm.
- Filters glitches with persistence counters and latches critical alarms until the operator acknowledges them.
- Counts critical episodes for the dashboard and telemetry.

Parameters:
PERSIST_CYC, 4, consecutive sampled cycles of a condition required to escalate (>=1)
CLEAR_CYC, 8, consecutive sampled cycles with both flags low required to de-escalate (>=1)
CNT_W, 8, width of critical-episode counter
ACK_TIMEOUT, 64, cycles in CRIT before auto-acknowledge (used only with AUTO_ACK_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset (0 = reset), sampled on clk rising edge
warning_in  input  1  warning flag from upstream emissions FSM
critical_in  input  1  critical flag from upstream emissions FSM
ack  input  1  operator acknowledge, level-sampled
alarm_level  output  2  0 = normal, 1 = warning, 2 = critical; 3 never driven
buzzer  output  1  audible alarm, high only in CRIT
latched_critical  output  1  high in CRIT and CRIT_ACK
event_pulse  output  1  one-cycle pulse on the first cycle in CRIT after entry
event_count  output  CNT_W  number of entries into CRIT, saturating

Behaviour:
- Reset (reset == 0 at an edge):
  - state = NORM; all run counters = 0; rearm = 0; event_count = 0.
  - All outputs are 0 from the next cycle.
  - Reset overrides every other input, including mid-CRIT.
- Input classification per edge:
  - crit = critical_in.
  - hot = warning_in | critical_in. When both flags are high, critical dominates.
  - cool = !warning_in & !critical_in.
- Run counters, each saturating:
  - crit_run counts consecutive crit samples, saturating at PERSIST_CYC.
  - hot_run counts consecutive hot samples, saturating at PERSIST_CYC.
  - cool_run counts consecutive cool samples, saturating at CLEAR_CYC.
  - Each counter clears to 0 on any sample that breaks its run.
- Transitions use the next (post-sample) counter values, so escalation occurs on the PERSIST_CYC-th consecutive qualifying edge.
- All outputs are registered, Moore-decoded from state.
  - Latency: first qualifying sample at edge 1 → output change visible after edge PERSIST_CYC.
- States:
  - NORM (level 0):
    - crit_run' == PERSIST_CYC → CRIT.
    - else hot_run' == PERSIST_CYC → WARN.
  - WARN (level 1):
    - crit_run' == PERSIST_CYC → CRIT.
    - else cool_run' == CLEAR_CYC → NORM.
    - Warning samples without enough persistence hold WARN.
  - CRIT (level 2, buzzer 1, latched 1):
    - ack == 1 → CRIT_ACK; rearm cleared.
    - ack is honoured only when sampled while already in CRIT. ack on the entry edge is ignored, so buzzer is high for at least one cycle.
  - CRIT_ACK (level 2, buzzer 0, latched 1):
    - Any sample with critical_in == 0 sets rearm.
    - rearm & crit_run' == PERSIST_CYC → CRIT.
    - else cool_run' == CLEAR_CYC → NORM.
    - Continuous critical after ack never re-alarms.
- ack outside CRIT is ignored.
- Entry into CRIT from any state:
  - event_count += 1, saturating at 2^CNT_W − 1.
  - event_pulse is high for exactly the first cycle in CRIT.
- Undefined state encodings recover to NORM on the next edge.

Optional Feature:
- Macro: EMISSION_AUTO_ACK_EN.
- Defined:
  - A timer counts cycles spent in CRIT.
  - After ACK_TIMEOUT cycles without ack, the FSM moves to CRIT_ACK exactly as if ack had been sampled (rearm cleared).
  - The timer resets on every CRIT entry.
- Undefined:
  - No timer logic is generated.
  - CRIT persists until ack or reset; ACK_TIMEOUT is unused.

Test Plan:
All scenarios use defaults PERSIST_CYC=4, CLEAR_CYC=8.
- Glitch rejection: reset low 2 edges; warning_in=1 for 3 edges then 0 → alarm_level stays 0, buzzer 0.
- Warning path: warning_in=1 for 4 edges → alarm_level=1 after 4th edge; then 0 for 7 edges → still 1; 8th edge → 0.
- Critical latch and ack: critical_in=1 for 4 edges → level 2, buzzer 1, event_pulse high 1 cycle, event_count=1; ack=1 one edge → buzzer 0, level 2; then 8 cool edges → level 0, latched 0.
- Dominance and ack timing:
  - warning_in=critical_in=1 for 4 edges → level 2 (not 1).
  - Repeat with ack=1 held from the first edge → buzzer still 1 on the entry cycle and drops after the next edge.
- Rearm: in CRIT_ACK hold critical_in=1 for 20 edges → no re-alarm; then 1 edge critical_in=0 followed by 4 edges critical_in=1 → CRIT again, buzzer 1, event_count=2.
- Reset and saturation:
  - reset=0 for one edge while in CRIT → all outputs 0 next cycle.
  - With CNT_W=2, 5 CRIT entries → event_count=3.
  - With EMISSION_AUTO_ACK_EN and ACK_TIMEOUT=10, no ack → buzzer falls after 10 cycles in CRIT.

Source files
------------

// File: rtl/emission_alert_manager.sv
// emission_alert_manager
// Turns the per-cycle warning/critical flags of the upstream emissions FSM
// into a stable, glitch-filtered alarm. Critical alarms latch until the
// operator acknowledges them, and critical episodes are counted.
//
// Optional feature macro: EMISSION_AUTO_ACK_EN
//   When defined, a timer auto-acknowledges CRIT after ACK_TIMEOUT cycles.
//   When undefined, no timer is built and CRIT persists until ack or reset.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous active-low reset
//   warning_in       warning flag from upstream
//   critical_in      critical flag from upstream (dominates warning)
//   ack              operator acknowledge, level-sampled, honoured in CRIT only
//   alarm_level      0 normal, 1 warning, 2 critical
//   buzzer           high only in CRIT
//   latched_critical high in CRIT and CRIT_ACK
//   event_pulse      one-cycle pulse on the first cycle in CRIT
//   event_count      saturating count of CRIT entries
module emission_alert_manager #(
    parameter int unsigned PERSIST_CYC = 4,
    parameter int unsigned CLEAR_CYC   = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             warning_in,
    input  logic             critical_in,
    input  logic             ack,
    output logic [1:0]       alarm_level,
    output logic             buzzer,
    output logic             latched_critical,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_count
);

    localparam int unsigned PW = $clog2(PERSIST_CYC + 1);
    localparam int unsigned CW = $clog2(CLEAR_CYC + 1);

    typedef enum logic [1:0] {
        NORM     = 2'd0,
        WARN     = 2'd1,
        CRIT     = 2'd2,
        CRIT_ACK = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [PW-1:0]  crit_run, crit_run_n;
    logic [PW-1:0]  hot_run, hot_run_n;
    logic [CW-1:0]  cool_run, cool_run_n;
    logic           rearm, rearm_n;
    logic           hot, cool;
    logic           crit_full, hot_full, cool_full;
    logic           enter_crit;
    logic [1:0]     level_n;
    logic [CNT_W-1:0] count_n;

`ifdef EMISSION_AUTO_ACK_EN
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0]  timer, timer_n;
`else
    // Keeps the parameter referenced when the auto-acknowledge timer is not built.
    logic unused_ack_timeout;
    assign unused_ack_timeout = (ACK_TIMEOUT == 32'd0);
`endif

    // Next-state, run counters and next registered outputs.
    always_comb begin
        hot  = warning_in | critical_in;
        cool = !warning_in && !critical_in;

        crit_run_n = '0;
        hot_run_n  = '0;
        cool_run_n = '0;
        if (critical_in)
            crit_run_n = (crit_run == PW'(PERSIST_CYC)) ? crit_run : crit_run + PW'(1);
        if (hot)
            hot_run_n = (hot_run == PW'(PERSIST_CYC)) ? hot_run : hot_run + PW'(1);
        if (cool)
            cool_run_n = (cool_run == CW'(CLEAR_CYC)) ? cool_run : cool_run + CW'(1);

        crit_full = (crit_run_n == PW'(PERSIST_CYC));
        hot_full  = (hot_run_n == PW'(PERSIST_CYC));
        cool_full = (cool_run_n == CW'(CLEAR_CYC));

        state_n = state;
        rearm_n = rearm;
`ifdef EMISSION_AUTO_ACK_EN
        // Timer restarts from zero on every CRIT entry.
        timer_n = (state == CRIT) ? timer + TW'(1) : '0;
`endif

        case (state)
            NORM: begin
                if (crit_full)     state_n = CRIT;
                else if (hot_full) state_n = WARN;
            end
            WARN: begin
                if (crit_full)      state_n = CRIT;
                else if (cool_full) state_n = NORM;
            end
            CRIT: begin
                // ack on the entry edge was sampled in the previous state, so
                // the buzzer always sounds for at least one cycle.
                if (ack) begin
                    state_n = CRIT_ACK;
                    rearm_n = 1'b0;
                end
`ifdef EMISSION_AUTO_ACK_EN
                else if (timer_n == TW'(ACK_TIMEOUT)) begin
                    state_n = CRIT_ACK;
                    rearm_n = 1'b0;
                end
`endif
            end
            CRIT_ACK: begin
                // A fresh critical run only re-alarms after critical dropped once.
                if (!critical_in) rearm_n = 1'b1;
                if (rearm && crit_full) state_n = CRIT;
                else if (cool_full)     state_n = NORM;
            end
            default: state_n = NORM;
        endcase

        enter_crit = (state_n == CRIT) && (state != CRIT);

        case (state_n)
            WARN:           level_n = 2'd1;
            CRIT, CRIT_ACK: level_n = 2'd2;
            default:        level_n = 2'd0;
        endcase

        count_n = event_count;
        if (enter_crit && (event_count != '1))
            count_n = event_count + CNT_W'(1);
    end

    // State, counters and Moore-decoded output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= NORM;
            crit_run         <= '0;
            hot_run          <= '0;
            cool_run         <= '0;
            rearm            <= 1'b0;
            alarm_level      <= 2'd0;
            buzzer           <= 1'b0;
            latched_critical <= 1'b0;
            event_pulse      <= 1'b0;
            event_count      <= '0;
`ifdef EMISSION_AUTO_ACK_EN
            timer            <= '0;
`endif
        end else begin
            state            <= state_n;
            crit_run         <= crit_run_n;
            hot_run          <= hot_run_n;
            cool_run         <= cool_run_n;
            rearm            <= rearm_n;
            alarm_level      <= level_n;
            buzzer           <= (state_n == CRIT);
            latched_critical <= (state_n == CRIT) || (state_n == CRIT_ACK);
            event_pulse      <= enter_crit;
            event_count      <= count_n;
`ifdef EMISSION_AUTO_ACK_EN
            timer            <= timer_n;
`endif
        end
    end

endmodule

// File: tb/tb_emission_alert_manager.sv
// Table-driven bench for emission_alert_manager (PERSIST_CYC=4, CLEAR_CYC=8).
// dut  : default parameters.
// dut2 : CNT_W=2 to observe event_count saturation.
// dut3 : ACK_TIMEOUT=10 to observe auto-acknowledge when enabled.
module tb_emission_alert_manager;

    logic clk = 1'b0;
    logic reset, warning_in, critical_in, ack;

    logic [1:0] alarm_level, alarm_level2, alarm_level3;
    logic       buzzer, buzzer2, buzzer3;
    logic       latched_critical, latched_critical2, latched_critical3;
    logic       event_pulse, event_pulse2, event_pulse3;
    logic [7:0] event_count, event_count3;
    logic [1:0] event_count2;

    int checks = 0;
    int errors = 0;
    int vec_idx = 0;

`ifdef EMISSION_AUTO_ACK_EN
    localparam bit AUTO_ACK = 1'b1;
`else
    localparam bit AUTO_ACK = 1'b0;
`endif

    always #5 clk = ~clk;

    emission_alert_manager dut (
        .clk(clk), .reset(reset), .warning_in(warning_in), .critical_in(critical_in), .ack(ack),
        .alarm_level(alarm_level), .buzzer(buzzer), .latched_critical(latched_critical),
        .event_pulse(event_pulse), .event_count(event_count)
    );

    emission_alert_manager #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .warning_in(warning_in), .critical_in(critical_in), .ack(ack),
        .alarm_level(alarm_level2), .buzzer(buzzer2), .latched_critical(latched_critical2),
        .event_pulse(event_pulse2), .event_count(event_count2)
    );

    emission_alert_manager #(.ACK_TIMEOUT(10)) dut3 (
        .clk(clk), .reset(reset), .warning_in(warning_in), .critical_in(critical_in), .ack(ack),
        .alarm_level(alarm_level3), .buzzer(buzzer3), .latched_critical(latched_critical3),
        .event_pulse(event_pulse3), .event_count(event_count3)
    );

    typedef struct {
        logic       rst;
        logic       w;
        logic       c;
        logic       a;
        logic [1:0] lvl;
        logic       buz;
        logic       lat;
        logic       pul;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic rst, logic w, logic c, logic a,
                                logic [1:0] lvl, logic buz, logic lat, logic pul, int cnt);
        vec_t v;
        v.rst = rst; v.w = w; v.c = c; v.a = a;
        v.lvl = lvl; v.buz = buz; v.lat = lat; v.pul = pul; v.cnt = cnt;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, vec_idx, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic w, logic c, logic a);
        reset = rst; warning_in = w; critical_in = c; ack = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        vec_idx++;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset
        add(2, 0,0,0,0, 2'd0,0,0,0, 0);
        // Glitch rejection: 3 warning edges are not enough
        add(3, 1,1,0,0, 2'd0,0,0,0, 0);
        add(1, 1,0,0,0, 2'd0,0,0,0, 0);
        // Warning path: escalate on 4th edge, clear on 8th cool edge
        add(3, 1,1,0,0, 2'd0,0,0,0, 0);
        add(1, 1,1,0,0, 2'd1,0,0,0, 0);
        add(7, 1,0,0,0, 2'd1,0,0,0, 0);
        add(1, 1,0,0,0, 2'd0,0,0,0, 0);
        // Critical latch, pulse, ack, then 8 cool edges back to normal
        add(3, 1,0,1,0, 2'd0,0,0,0, 0);
        add(1, 1,0,1,0, 2'd2,1,1,1, 1);
        add(1, 1,0,1,0, 2'd2,1,1,0, 1);
        add(1, 1,0,1,1, 2'd2,0,1,0, 1);
        add(7, 1,0,0,0, 2'd2,0,1,0, 1);
        add(1, 1,0,0,0, 2'd0,0,0,0, 1);
        // Both flags high: critical dominates
        add(3, 1,1,1,0, 2'd0,0,0,0, 1);
        add(1, 1,1,1,0, 2'd2,1,1,1, 2);
        add(1, 1,1,1,1, 2'd2,0,1,0, 2);
        add(7, 1,0,0,0, 2'd2,0,1,0, 2);
        add(1, 1,0,0,0, 2'd0,0,0,0, 2);
        // ack held from the first edge: ignored until sampled inside CRIT
        add(3, 1,1,1,1, 2'd0,0,0,0, 2);
        add(1, 1,1,1,1, 2'd2,1,1,1, 3);
        add(1, 1,1,1,1, 2'd2,0,1,0, 3);
        // Continuous critical after ack never re-alarms; a low sample rearms
        add(20, 1,0,1,0, 2'd2,0,1,0, 3);
        add(1,  1,0,0,0, 2'd2,0,1,0, 3);
        add(3,  1,0,1,0, 2'd2,0,1,0, 3);
        add(1,  1,0,1,0, 2'd2,1,1,1, 4);
        add(1,  1,0,1,0, 2'd2,1,1,0, 4);
        // Reset mid-CRIT overrides everything
        add(1, 0,0,1,0, 2'd0,0,0,0, 0);
        add(1, 1,0,0,0, 2'd0,0,0,0, 0);
        // Five CRIT entries via ack/rearm cycles
        add(3, 1,0,1,0, 2'd0,0,0,0, 0);
        add(1, 1,0,1,0, 2'd2,1,1,1, 1);
        for (int k = 2; k <= 5; k++) begin
            add(1, 1,0,1,1, 2'd2,0,1,0, k-1);
            add(1, 1,0,0,0, 2'd2,0,1,0, k-1);
            add(3, 1,0,1,0, 2'd2,0,1,0, k-1);
            add(1, 1,0,1,0, 2'd2,1,1,1, k);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].w, vecs[i].c, vecs[i].a);
            step();
            chk("alarm_level", int'(alarm_level), int'(vecs[i].lvl));
            chk("buzzer", int'(buzzer), int'(vecs[i].buz));
            chk("latched_critical", int'(latched_critical), int'(vecs[i].lat));
            chk("event_pulse", int'(event_pulse), int'(vecs[i].pul));
            chk("event_count", int'(event_count), vecs[i].cnt);
            chk("event_count_w2", int'(event_count2), (vecs[i].cnt > 3) ? 3 : vecs[i].cnt);
            chk("alarm_level_w2", int'(alarm_level2), int'(vecs[i].lvl));
        end

        // ack in WARN ignored; direct WARN -> CRIT escalation
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("rst_level", int'(alarm_level), 0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            step();
            chk("warn_ack_level", int'(alarm_level), (i == 4) ? 1 : 0);
            chk("warn_ack_buzzer", int'(buzzer), 0);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            step();
            chk("warn_to_crit_level", int'(alarm_level), (i == 4) ? 2 : 1);
            chk("warn_to_crit_pulse", int'(event_pulse), (i == 4) ? 1 : 0);
        end
        chk("warn_to_crit_count", int'(event_count), 1);

        // Long CRIT without ack: auto-acknowledge only when the feature is built
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            step();
        end
        chk("auto_entry_buzzer", int'(buzzer3), 1);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("auto_buzzer", int'(buzzer3), (AUTO_ACK && i >= 10) ? 0 : 1);
            chk("auto_latched", int'(latched_critical3), 1);
            chk("auto_level", int'(alarm_level3), 2);
            chk("default_timeout_buzzer", int'(buzzer), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
